param_mc_cpu: RTL and testbench

//  Parametrised multi-cycle accumulator-style CPU core: 32-bit instructions, GPR file, data memory.

---
 rtl/param_mc_cpu_pkg.sv | 30 +++
 rtl/param_mc_cpu_alu.sv | 27 ++
 rtl/param_mc_cpu.sv | 140 ++++++++++++++
 tb/tb_param_mc_cpu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_mc_cpu_pkg.sv
// param_mc_cpu_pkg: opcodes, FSM states, instruction decode and ALU flag types
package param_mc_cpu_pkg;
    localparam logic [4:0] OP_MOV   = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_SUB   = 5'b00011;
    localparam logic [4:0] OP_MUL   = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b01100;
    localparam logic [4:0] OP_STORE = 5'b01101;
    localparam logic [4:0] OP_DIN   = 5'b01110;
    localparam logic [4:0] OP_DOUT  = 5'b01111;
    localparam logic [4:0] OP_JUMP  = 5'b10000;
    localparam logic [4:0] OP_JZ    = 5'b10001;
    localparam logic [4:0] OP_HALT  = 5'b11111;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT_DIN, S_SEND, S_HALT} state_t;
    // rsrc2 is not a separate field: it aliases isrc[15:11]
    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rdst;
        logic [4:0]  rsrc1;
        logic        imm;
        logic [15:0] isrc;
    } ir_t;
    typedef struct packed {
        logic z;
        logic c;
    } alu_flags_t;
    function automatic ir_t decode(input logic [31:0] w);
        return ir_t'(w);
    endfunction
endpackage

// File: rtl/param_mc_cpu_alu.sv
// param_mc_cpu_alu: combinational mov/add/sub/mul with zero, carry/borrow and high product half
module param_mc_cpu_alu import param_mc_cpu_pkg::*; #(
    parameter int DATA_W = 16
) (
    input  logic [4:0]        op,
    input  logic              imm,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic [DATA_W-1:0] hi,
    output alu_flags_t        fl
);
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        res  = op == OP_ADD ? sum[DATA_W-1:0] :
               op == OP_SUB ? diff[DATA_W-1:0] :
               op == OP_MUL ? prod[DATA_W-1:0] : imm ? b : a;
        hi   = prod[2*DATA_W-1:DATA_W];
        fl.c = op == OP_SUB ? diff[DATA_W] : sum[DATA_W];
        fl.z = res == '0;
    end
endmodule

// File: rtl/param_mc_cpu.sv
// param_mc_cpu: multi-cycle accumulator-style core with loadable imem, dmem and din/dout handshakes
module param_mc_cpu import param_mc_cpu_pkg::*; #(
    parameter int DATA_W     = 16,
    parameter int NUM_GPR    = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic                          run,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [31:0]                   prog_data,
    input  logic [DATA_W-1:0]             din,
    input  logic                          din_valid,
    output logic                          din_ready,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc,
    output logic                          halted,
    output logic                          illegal
);
    localparam int PW = $clog2(IMEM_DEPTH);
    localparam int AW = $clog2(DMEM_DEPTH);
    localparam logic [5:0] NG = 6'(NUM_GPR);
    logic [31:0]       imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] gpr [32];
    state_t            state, nxt;
    logic [31:0]       ir;
    ir_t               d;
    logic [DATA_W-1:0] sgpr, a, b, res, hi, wd, dwd;
    logic              z_q, c_q, gwe, dwe;
    alu_flags_t        fl;
    logic [AW-1:0]     da;
    logic [PW-1:0]     pc_inc, tgt;
    // unimplemented registers read as zero
    function automatic logic [DATA_W-1:0] rd(input logic [4:0] i);
        return {1'b0, i} < NG ? gpr[i] : '0;
    endfunction
    always_comb begin
        d      = decode(ir);
        a      = rd(d.rsrc1);
        b      = d.imm ? DATA_W'(d.isrc) : rd(d.isrc[15:11]);
        da     = d.isrc[AW-1:0];
        tgt    = d.isrc[PW-1:0];
        pc_inc = pc + 1'b1;
        nxt    = run ? S_FETCH : S_IDLE;
        gwe    = state == S_EXEC && {1'b0, d.rdst} < NG &&
                 (d.op inside {OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_LOAD});
        wd     = d.op == OP_LOAD ? dmem[da] : res;
        dwe    = (state == S_EXEC && d.op == OP_STORE) || (state == S_WAIT_DIN && din_valid);
        dwd    = state == S_WAIT_DIN ? din : a;
    end
    param_mc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op (d.op),
        .imm(d.imm),
        .a  (a),
        .b  (b),
        .res(res),
        .hi (hi),
        .fl (fl)
    );
    // memories are never cleared; a reset edge blocks any pending dmem write
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE || state == S_HALT)) imem[prog_addr] <= prog_data;
        if (dwe && !sys_rst) dmem[da] <= dwd;
    end
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            sgpr       <= '0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            din_ready  <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
        end else begin
            if (gwe) gpr[d.rdst] <= wd;
            case (state)
                S_IDLE: if (run) state <= S_FETCH;
                S_FETCH: begin
                    ir    <= imem[pc];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= nxt;
                    pc    <= pc_inc;
                    case (d.op)
                        OP_MOV, OP_LOAD, OP_STORE: ;
                        OP_ADD, OP_SUB: begin
                            z_q <= fl.z;
                            c_q <= fl.c;
                        end
                        OP_MUL: begin
                            z_q  <= fl.z;
                            sgpr <= hi;
                        end
                        OP_DIN: begin
                            state     <= S_WAIT_DIN;
                            pc        <= pc;
                            din_ready <= 1'b1;
                        end
                        OP_DOUT: begin
                            state      <= S_SEND;
                            pc         <= pc;
                            dout       <= dmem[da];
                            dout_valid <= 1'b1;
                        end
                        OP_JUMP: pc <= tgt;
                        OP_JZ: if (z_q) pc <= tgt;
                        OP_HALT: begin
                            state  <= S_HALT;
                            pc     <= pc;
                            halted <= 1'b1;
                        end
                        default: illegal <= 1'b1;
                    endcase
                end
                S_WAIT_DIN: if (din_valid) begin
                    din_ready <= 1'b0;
                    pc        <= pc_inc;
                    state     <= nxt;
                end
                S_SEND: if (dout_ready) begin
                    dout_valid <= 1'b0;
                    pc         <= pc_inc;
                    state      <= nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_param_mc_cpu.sv
// tb_param_mc_cpu: scenario tasks plus randomized ALU programs checked against an ISA-level model
module tb_param_mc_cpu;
    import param_mc_cpu_pkg::*;
    logic        clk = 1'b0;
    logic        sys_rst, run, prog_we, din_valid, din_ready, dout_valid, dout_ready, halted, illegal;
    logic [3:0]  prog_addr, pc;
    logic [31:0] prog_data;
    logic [15:0] din, dout;
    int          total = 0;
    int          bad = 0;
    logic [15:0] got[$];

    param_mc_cpu dut (
        .clk(clk), .sys_rst(sys_rst), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .pc(pc),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dout_valid === 1'b1 && dout_ready === 1'b1) got.push_back(dout);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rdst,
                                        input logic [4:0] rs1, input logic im, input logic [15:0] src);
        return {op, rdst, rs1, im, src};
    endfunction

    function automatic logic [4:0] alu_op(input int s);
        return s == 0 ? 5'b00010 : s == 1 ? 5'b00011 : 5'b00100;
    endfunction

    // instruction-level meaning of add/sub/mul on 16-bit words
    function automatic logic [15:0] model(input int s, input logic [15:0] x, input logic [15:0] y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint unsigned r = s == 0 ? ux + uy : s == 1 ? ux + 65536 - uy : ux * uy;
        return 16'(r % 65536);
    endfunction

    task automatic boot();
        sys_rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 sys_rst = 1'b0;
        got.delete();
    endtask

    task automatic put(input logic [3:0] adr, input logic [31:0] w);
        prog_we = 1'b1; prog_addr = adr; prog_data = w;
        @(posedge clk);
        #1 prog_we = 1'b0;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (halted === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        boot();
        @(negedge clk);
        total++; if (pc !== 4'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", pc); end
        total++; if ({halted, illegal} !== 2'b00) begin bad++; $display("FAIL reset_halt_ill got=%b want=00", {halted, illegal}); end
        total++; if ({dout_valid, din_ready} !== 2'b00) begin bad++; $display("FAIL reset_valids got=%b want=00", {dout_valid, din_ready}); end
        total++; if (dout !== 16'h0) begin bad++; $display("FAIL reset_dout got=%h want=0000", dout); end
    endtask

    task automatic test_basic();
        boot();
        put(0, ins(5'b00001, 1, 0, 1, 16'd5));
        put(1, ins(5'b00010, 2, 1, 1, 16'd3));
        put(2, ins(5'b11111, 0, 0, 0, 16'd0));
        run = 1'b1;
        wait_halt();
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL t1_halted got=%b want=1", halted); end
        total++; if (pc !== 4'd2) begin bad++; $display("FAIL t1_pc got=%0d want=2", pc); end
        total++; if (dut.gpr[2] !== 16'd8) begin bad++; $display("FAIL t1_r2 got=%0d want=8", dut.gpr[2]); end
    endtask

    task automatic test_flags();
        boot();
        put(0, ins(5'b00001, 1, 0, 1, 16'hFFFF));
        put(1, ins(5'b00010, 2, 1, 1, 16'd1));
        put(2, ins(5'b10001, 0, 0, 0, 16'd7));
        put(7, ins(5'b11111, 0, 0, 0, 16'd0));
        run = 1'b1;
        wait_halt();
        total++; if (pc !== 4'd7) begin bad++; $display("FAIL t2_jz_taken_pc got=%0d want=7", pc); end
        total++; if (dut.gpr[2] !== 16'h0) begin bad++; $display("FAIL t2_add_wrap got=%h want=0000", dut.gpr[2]); end
        total++; if ({dut.z_q, dut.c_q} !== 2'b11) begin bad++; $display("FAIL t2_zc_add got=%b want=11", {dut.z_q, dut.c_q}); end
        boot();
        put(0, ins(5'b00001, 1, 0, 1, 16'd5));
        put(1, ins(5'b00011, 2, 1, 1, 16'd7));
        put(2, ins(5'b10001, 0, 0, 0, 16'd7));
        put(3, ins(5'b11111, 0, 0, 0, 16'd0));
        run = 1'b1;
        wait_halt();
        total++; if (pc !== 4'd3) begin bad++; $display("FAIL t2_jz_not_taken_pc got=%0d want=3", pc); end
        total++; if (dut.gpr[2] !== 16'hFFFE) begin bad++; $display("FAIL t2_sub got=%h want=fffe", dut.gpr[2]); end
        total++; if ({dut.z_q, dut.c_q} !== 2'b01) begin bad++; $display("FAIL t2_zc_sub got=%b want=01", {dut.z_q, dut.c_q}); end
        boot();
        put(0, ins(5'b00001, 1, 0, 1, 16'h1234));
        put(1, ins(5'b00100, 3, 1, 1, 16'h0100));
        put(2, ins(5'b11111, 0, 0, 0, 16'd0));
        run = 1'b1;
        wait_halt();
        total++; if (dut.gpr[3] !== 16'h3400) begin bad++; $display("FAIL t2_mul_lo got=%h want=3400", dut.gpr[3]); end
        total++; if (dut.sgpr !== 16'h0012) begin bad++; $display("FAIL t2_mul_hi got=%h want=0012", dut.sgpr); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [15:0] v0, v1, v2, e1, e2;
            int oa, ob;
            v0 = 16'($urandom); v1 = 16'($urandom); v2 = 16'($urandom);
            oa = int'($urandom_range(0, 2)); ob = int'($urandom_range(0, 2));
            e1 = model(oa, v0, v1);
            e2 = model(ob, e1, v2);
            boot();
            put(0, ins(5'b00001, 1, 0, 1, v0));
            put(1, ins(5'b00001, 2, 0, 1, v1));
            put(2, ins(alu_op(oa), 3, 1, 0, {5'd2, 11'd0}));
            put(3, ins(5'b01101, 0, 3, 0, 16'd5));
            put(4, ins(alu_op(ob), 3, 3, 1, v2));
            put(5, ins(5'b01101, 0, 3, 0, 16'd6));
            put(6, ins(5'b01111, 0, 0, 0, 16'd5));
            put(7, ins(5'b01111, 0, 0, 0, 16'd6));
            put(8, ins(5'b11111, 0, 0, 0, 16'd0));
            run = 1'b1;
            wait_halt();
            total++;
            if (got.size() != 2) begin
                bad++; $display("FAIL rand%0d_count got=%0d want=2", it, got.size());
            end else begin
                total++; if (got[0] !== e1) begin bad++; $display("FAIL rand%0d_first op=%0d got=%h want=%h", it, oa, got[0], e1); end
                total++; if (got[1] !== e2) begin bad++; $display("FAIL rand%0d_second op=%0d got=%h want=%h", it, ob, got[1], e2); end
            end
        end
    endtask

    task automatic test_din_dout();
        logic held;
        boot();
        put(0, ins(5'b01110, 0, 0, 0, 16'd3));
        put(1, ins(5'b01111, 0, 0, 0, 16'd3));
        put(2, ins(5'b11111, 0, 0, 0, 16'd0));
        dout_ready = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (din_ready === 1'b1) break; end
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (din_ready !== 1'b1) held = 1'b0; end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL t3_din_ready_held got=0 want=1"); end
        @(posedge clk); #1 din = 16'hBEEF; din_valid = 1'b1;
        @(posedge clk); #1 din_valid = 1'b0; din = 16'h0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (dout_valid === 1'b1) break; end
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (dout_valid !== 1'b1 || dout !== 16'hBEEF) held = 1'b0; end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL t3_dout_held got=%b/%h want=1/beef", dout_valid, dout); end
        @(posedge clk); #1 dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL t3_valid_drop got=%b want=0", dout_valid); end
        wait_halt();
        total++; if (pc !== 4'd2) begin bad++; $display("FAIL t3_pc got=%0d want=2", pc); end
        total++; if (got.size() != 1 || got[0] !== 16'hBEEF) begin bad++; $display("FAIL t3_transfer got_n=%0d want=1 beef", got.size()); end
    endtask

    task automatic test_jump_wrap();
        boot();
        put(0, ins(5'b10001, 0, 0, 0, 16'd5));
        put(1, ins(5'b00001, 1, 0, 1, 16'd7));
        put(2, ins(5'b10000, 0, 0, 0, 16'd15));
        put(15, ins(5'b00011, 2, 1, 0, {5'd1, 11'd0}));
        put(5, ins(5'b01101, 0, 1, 0, 16'h0013));
        put(6, ins(5'b01111, 0, 0, 0, 16'd3));
        put(7, ins(5'b11111, 0, 0, 0, 16'd0));
        run = 1'b1;
        wait_halt();
        total++; if (pc !== 4'd7) begin bad++; $display("FAIL t4_pc got=%0d want=7", pc); end
        total++; if (dut.gpr[2] !== 16'h0) begin bad++; $display("FAIL t4_r2 got=%h want=0000", dut.gpr[2]); end
        total++; if (got.size() != 1 || got[0] !== 16'd7) begin bad++; $display("FAIL t4_dmem3 got_n=%0d want=1 value 7", got.size()); end
    endtask

    task automatic test_reset_abort();
        boot();
        put(0, ins(5'b01111, 0, 0, 0, 16'd3));
        put(1, ins(5'b11111, 0, 0, 0, 16'd0));
        dout_ready = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (dout_valid === 1'b1) break; end
        total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL t5_send_reached got=%b want=1", dout_valid); end
        @(posedge clk); #1 sys_rst = 1'b1; run = 1'b0;
        @(posedge clk); #1 sys_rst = 1'b0;
        @(negedge clk);
        total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL t5_valid got=%b want=0", dout_valid); end
        total++; if (pc !== 4'd0) begin bad++; $display("FAIL t5_pc got=%0d want=0", pc); end
        total++; if (dut.state !== S_IDLE) begin bad++; $display("FAIL t5_state got=%0d want=%0d", dut.state, S_IDLE); end
        put(0, ins(5'b01110, 0, 0, 0, 16'd3));
        dout_ready = 1'b1;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (din_ready === 1'b1) break; end
        @(posedge clk); #1 din = 16'h5555; din_valid = 1'b1; sys_rst = 1'b1; run = 1'b0;
        @(posedge clk); #1 sys_rst = 1'b0; din_valid = 1'b0;
        @(negedge clk);
        total++; if (din_ready !== 1'b0) begin bad++; $display("FAIL t5_din_ready got=%b want=0", din_ready); end
        put(0, ins(5'b01111, 0, 0, 0, 16'd3));
        got.delete();
        run = 1'b1;
        wait_halt();
        total++; if (got.size() != 1 || got[0] !== 16'd7) begin bad++; $display("FAIL t5_dmem_kept got_n=%0d want=1 value 7", got.size()); end
    endtask

    task automatic test_illegal();
        logic [15:0] r;
        logic [3:0]  p;
        boot();
        put(0, ins(5'b00001, 1, 0, 1, 16'd9));
        put(1, ins(5'b11010, 1, 1, 1, 16'h0055));
        put(2, ins(5'b11111, 0, 0, 0, 16'd0));
        run = 1'b1;
        wait_halt();
        total++; if (illegal !== 1'b1) begin bad++; $display("FAIL t6_illegal got=%b want=1", illegal); end
        total++; if (dut.gpr[1] !== 16'd9) begin bad++; $display("FAIL t6_r1 got=%0d want=9", dut.gpr[1]); end
        total++; if (pc !== 4'd2) begin bad++; $display("FAIL t6_pc got=%0d want=2", pc); end
        boot();
        put(0, ins(5'b00010, 1, 1, 1, 16'd1));
        put(1, ins(5'b10000, 0, 0, 0, 16'd0));
        run = 1'b1;
        repeat (6) @(posedge clk);
        #1 put(1, ins(5'b11111, 0, 0, 0, 16'd0));
        repeat (20) @(negedge clk);
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL t6_prog_we_halted got=%b want=0", halted); end
        total++; if (dut.imem[1] !== ins(5'b10000, 0, 0, 0, 16'd0)) begin bad++; $display("FAIL t6_imem got=%h want=%h", dut.imem[1], ins(5'b10000, 0, 0, 0, 16'd0)); end
        @(posedge clk); #1 run = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (dut.state !== S_IDLE) begin bad++; $display("FAIL t6_stop_state got=%0d want=%0d", dut.state, S_IDLE); end
        r = dut.gpr[1]; p = pc;
        repeat (5) @(negedge clk);
        total++; if (dut.gpr[1] !== r || pc !== p) begin bad++; $display("FAIL t6_stopped got=%0d/%0d want=%0d/%0d", dut.gpr[1], pc, r, p); end
        @(posedge clk); #1 put(1, ins(5'b11111, 0, 0, 0, 16'd0));
        run = 1'b1;
        wait_halt();
        total++; if (halted !== 1'b1 || pc !== 4'd1) begin bad++; $display("FAIL t6_idle_prog got=%b/%0d want=1/1", halted, pc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_random();
        test_din_dout();
        test_jump_wrap();
        test_reset_abort();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
